// File: rtl/mram_pm_pkg.sv
// Shared types and constants for the MRAM power manager and its watchdog.
package mram_pm_pkg;

    typedef enum logic [2:0] {
        PM_OFF      = 3'd0,
        PM_WAKING   = 3'd1,
        PM_ON       = 3'd2,
        PM_SLEEPING = 3'd3,
        PM_ERROR    = 3'd4
    } pm_state_t;

    localparam int PM_TIMEOUT_W       = 8;
    localparam int PM_TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/pm_watchdog.sv
// Sequence watchdog: clearable, enabled counter with a terminal-count flag at LIMIT-1.
module pm_watchdog
    import mram_pm_pkg::*;
#(
    parameter int LIMIT = PM_TIMEOUT_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    output logic [PM_TIMEOUT_W-1:0] count,
    output logic                    tc
);

    logic [PM_TIMEOUT_W-1:0] count_next;

    // Saturates so a stalled enable can never wrap back into the blanking window.
    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (en && (count != '1)) begin
            count_next = count + 1'b1;
        end
    end

    reg_arstn #(.W(PM_TIMEOUT_W)) u_count_reg (
        .clk (clk),
        .rst (rst),
        .d   (count_next),
        .q   (count)
    );

    assign tc = (count == PM_TIMEOUT_W'(LIMIT - 1));

endmodule

// File: rtl/reg_arstn.sv
// Plain D flop bank with asynchronous active-low clear to zero.
module reg_arstn #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mram_power_manager.sv
// MRAM power manager: turns wake/sleep requests, bus demand and idle time into the
// power level for the power-gate sequencer, with a done-handshake watchdog.
module mram_power_manager
    import mram_pm_pkg::*;
#(
    parameter int IDLE_CNT_W  = 16,
    parameter int TIMEOUT_CYC = PM_TIMEOUT_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wake_req_i,
    input  logic                  sleep_req_i,
    input  logic                  auto_sleep_en_i,
    input  logic [IDLE_CNT_W-1:0] idle_limit_i,
    input  logic                  err_clr_i,
    input  logic                  mem_req_i,
    output logic                  mem_gnt_o,
    input  logic                  pg_done_i,
    output logic                  power_o,
    output logic                  powered_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic                  irq_o
);

    logic [2:0]              state_reg;
    pm_state_t               state;
    pm_state_t               state_next;
    logic                    pend_wake_reg, pend_wake_next;
    logic                    pend_sleep_reg, pend_sleep_next;
    logic [IDLE_CNT_W-1:0]   idle_reg, idle_next;
    logic [4:0]              out_reg, out_next;
    logic [PM_TIMEOUT_W-1:0] wd_count;
    logic                    wd_tc;
    logic                    seq_active;
    logic                    done_qual;
    logic                    sleep_cond;

    assign state      = pm_state_t'(state_reg);
    assign seq_active = (state == PM_WAKING) || (state == PM_SLEEPING);
    // The first sequence cycle (count still 0) blanks a stale done from the previous sequence.
    assign done_qual  = pg_done_i && (wd_count != '0);
    assign sleep_cond = sleep_req_i || pend_sleep_reg ||
                        (auto_sleep_en_i && (idle_limit_i != '0) &&
                         (idle_reg >= (idle_limit_i - IDLE_CNT_W'(1))));

    pm_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (!seq_active),
        .en    (seq_active),
        .count (wd_count),
        .tc    (wd_tc)
    );

    always_comb begin
        state_next      = state;
        pend_wake_next  = pend_wake_reg;
        pend_sleep_next = pend_sleep_reg;
        idle_next       = '0;
        case (state)
            PM_OFF: begin
                if (wake_req_i || mem_req_i || pend_wake_reg) begin
                    state_next     = PM_WAKING;
                    pend_wake_next = 1'b0;
                    if (wake_req_i && sleep_req_i) begin
                        pend_sleep_next = 1'b1;
                    end
                end
            end
            PM_WAKING: begin
                if (sleep_req_i) begin
                    pend_sleep_next = 1'b1;
                end
                if (done_qual) begin
                    state_next = PM_ON;
                end else if (wd_tc) begin
                    state_next = PM_ERROR;
                end
            end
            PM_ON: begin
                if (mem_req_i) begin
                    idle_next = '0;
                end else if (idle_reg != '1) begin
                    idle_next = idle_reg + 1'b1;
                end else begin
                    idle_next = idle_reg;
                end
                // An in-flight access defers the power-down until the bus goes quiet.
                if (sleep_cond) begin
                    if (mem_req_i) begin
                        pend_sleep_next = 1'b1;
                    end else begin
                        state_next      = PM_SLEEPING;
                        pend_sleep_next = 1'b0;
                    end
                end
            end
            PM_SLEEPING: begin
                if (wake_req_i || mem_req_i) begin
                    pend_wake_next = 1'b1;
                end
                if (done_qual) begin
                    state_next = PM_OFF;
                end else if (wd_tc) begin
                    state_next = PM_ERROR;
                end
            end
            PM_ERROR: begin
                pend_wake_next  = 1'b0;
                pend_sleep_next = 1'b0;
                if (err_clr_i) begin
                    state_next = PM_OFF;
                end
            end
            default: begin
                state_next      = PM_OFF;
                pend_wake_next  = 1'b0;
                pend_sleep_next = 1'b0;
            end
        endcase
    end

    // Output bits: {power, powered, busy, err, irq}, all decoded from the state being entered.
    always_comb begin
        out_next    = '0;
        out_next[4] = (state_next == PM_WAKING) || (state_next == PM_ON);
        out_next[3] = (state_next == PM_ON);
        out_next[2] = (state_next == PM_WAKING) || (state_next == PM_SLEEPING);
        out_next[1] = (state_next == PM_ERROR);
        out_next[0] = (state_next != state) &&
                      ((state_next == PM_ON) || (state_next == PM_ERROR) ||
                       ((state_next == PM_OFF) && (state == PM_SLEEPING)));
    end

    reg_arstn #(.W(3)) u_state_reg (
        .clk (clk),
        .rst (rst),
        .d   (state_next),
        .q   (state_reg)
    );

    reg_arstn #(.W(2)) u_pend_reg (
        .clk (clk),
        .rst (rst),
        .d   ({pend_wake_next, pend_sleep_next}),
        .q   ({pend_wake_reg, pend_sleep_reg})
    );

    reg_arstn #(.W(IDLE_CNT_W)) u_idle_reg (
        .clk (clk),
        .rst (rst),
        .d   (idle_next),
        .q   (idle_reg)
    );

    reg_arstn #(.W(5)) u_out_reg (
        .clk (clk),
        .rst (rst),
        .d   (out_next),
        .q   (out_reg)
    );

    assign power_o   = out_reg[4];
    assign powered_o = out_reg[3];
    assign busy_o    = out_reg[2];
    assign err_o     = out_reg[1];
    assign irq_o     = out_reg[0];
    assign mem_gnt_o = mem_req_i && (state == PM_ON);

endmodule
